spi_frame_receiver: RTL and testbench



---
 rtl/spi_rx_pkg.sv | 13 +
 rtl/spi_frame_receiver_if.sv | 27 ++
 rtl/pin_synchronizer.sv | 19 +
 rtl/spi_frame_receiver.sv | 131 +++++++++++++
 tb/tb_spi_frame_receiver.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/spi_rx_pkg.sv
// Shared encodings and defaults for the SPI frame receiver.
package spi_rx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LATCH = 2'b10
  } state_e;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_FRAME_BITS   = 32;
  localparam int DEF_LATCH_CYCLES = 4;
  localparam int RB_BITS          = 16;
endpackage

// File: rtl/spi_frame_receiver_if.sv
// SPI pins plus the controller-side command/readback signals of the receiver.
interface spi_frame_receiver_if
  import spi_rx_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS
);
  logic                  enable_sn;
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic [RB_BITS-1:0]    readback_data;
  logic                  readback_valid_n;
  logic [FRAME_BITS-1:0] spi_data;
  logic                  latch_data_sn;
  logic                  frame_error;

  modport master (
    output enable_sn, sclk, cs_n, mosi, readback_data, readback_valid_n,
    input  miso, spi_data, latch_data_sn, frame_error
  );

  modport slave (
    input  enable_sn, sclk, cs_n, mosi, readback_data, readback_valid_n,
    output miso, spi_data, latch_data_sn, frame_error
  );
endinterface

// File: rtl/pin_synchronizer.sv
// Multi-flop synchronizer for one slow asynchronous pin.
module pin_synchronizer #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) chain <= {STAGES{RST_VAL}};
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/spi_frame_receiver.sv
// Oversampled SPI mode-0 slave: assembles command frames, strobes latch_data_sn,
// and shifts the controller's last readback word out on MISO.
module spi_frame_receiver
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  spi_frame_receiver_if.slave  bus
);
  localparam int CW    = $clog2(FRAME_BITS + 2);
  localparam int LW    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int FLUSH = SYNC_STAGES + 1;
  localparam int FW    = $clog2(FLUSH + 1);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d, mosi_d;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [FW-1:0] flush_cnt;
  logic armed;

  pin_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clock(clock), .reset(reset), .d(bus.sclk), .q(sclk_s));
  pin_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clock(clock), .reset(reset), .d(bus.cs_n), .q(cs_s));
  pin_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .d(bus.mosi), .q(mosi_s));

  // Edge pulses are registered so mosi_d lines up with sclk_rise.
  // armed blocks the fake cs fall produced when the chain flushes its reset 1
  // while the pin is already low (reset mid-frame).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_d <= 1'b0; cs_d <= 1'b1; mosi_d <= 1'b0;
      sclk_rise <= 1'b0; sclk_fall <= 1'b0; cs_rise <= 1'b0; cs_fall <= 1'b0;
      flush_cnt <= '0; armed <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      mosi_d    <= mosi_s;
      sclk_rise <= sclk_s & ~sclk_d;
      sclk_fall <= ~sclk_s & sclk_d;
      cs_rise   <= cs_s & ~cs_d;
      cs_fall   <= ~cs_s & cs_d;
      if (flush_cnt != FW'(FLUSH)) flush_cnt <= flush_cnt + 1'b1;
      armed     <= armed | ((flush_cnt == FW'(FLUSH)) & cs_d);
    end
  end

  state_e                state, state_nxt;
  logic [CW-1:0]         bit_count, bit_nxt;
  logic [FRAME_BITS-1:0] rx_shift, rx_nxt;
  logic [FRAME_BITS-1:0] tx_shift, tx_nxt;
  logic [FRAME_BITS-1:0] spi_q, spi_nxt;
  logic [LW-1:0]         lcnt, lcnt_nxt;
  logic [RB_BITS-1:0]    hold;
  logic                  latch_q, latch_nxt;
  logic                  err_q, err_nxt;

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_count;
    rx_nxt    = rx_shift;
    tx_nxt    = tx_shift;
    spi_nxt   = spi_q;
    lcnt_nxt  = lcnt;
    latch_nxt = latch_q;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (cs_fall && armed) begin
        state_nxt = SHIFT;
        bit_nxt   = '0;
        tx_nxt    = {hold, {(FRAME_BITS-RB_BITS){1'b0}}};
      end
      SHIFT: if (cs_rise) begin
        if (bit_count == CW'(FRAME_BITS)) begin
          state_nxt = LATCH;
          spi_nxt   = rx_shift;
          latch_nxt = 1'b0;
          lcnt_nxt  = LW'(LATCH_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end else begin
        if (sclk_rise) begin
          rx_nxt = {rx_shift[FRAME_BITS-2:0], mosi_d};
          if (bit_count != CW'(FRAME_BITS + 1)) bit_nxt = bit_count + 1'b1;
        end
        if (sclk_fall) tx_nxt = tx_shift << 1;
      end
      LATCH: if (lcnt == '0) begin
        state_nxt = IDLE;
        latch_nxt = 1'b1;
      end else begin
        lcnt_nxt = lcnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.enable_sn) begin
      state_nxt = IDLE;
      bit_nxt   = '0;
      spi_nxt   = spi_q;
      latch_nxt = 1'b1;
      err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE; bit_count <= '0; rx_shift <= '0; tx_shift <= '0;
      spi_q <= '0; lcnt <= '0; latch_q <= 1'b1; err_q <= 1'b0;
    end else begin
      state <= state_nxt; bit_count <= bit_nxt; rx_shift <= rx_nxt; tx_shift <= tx_nxt;
      spi_q <= spi_nxt; lcnt <= lcnt_nxt; latch_q <= latch_nxt; err_q <= err_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      hold <= '0;
    else if (!bus.readback_valid_n) hold <= bus.readback_data;
  end

  assign bus.miso          = (state == SHIFT && !cs_d) ? tx_shift[FRAME_BITS-1] : 1'b0;
  assign bus.spi_data      = spi_q;
  assign bus.latch_data_sn = latch_q;
  assign bus.frame_error   = err_q;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed frames with a scoreboard of expected latch/error events.
module tb_spi_frame_receiver;
  import spi_rx_pkg::*;
  localparam int SS = 2;
  localparam int LC = 4;

  logic clock = 1'b0;
  logic reset;
  spi_frame_receiver_if bus ();

  spi_frame_receiver #(.SYNC_STAGES(SS), .FRAME_BITS(32), .LATCH_CYCLES(LC)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_err = 0, cyc = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic pop_cmp(input bit is_err);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_event: got %s at cycle %0d, want none", is_err ? "error" : "latch", cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(is_err), 32'(e.is_err));
      check("spi_data", bus.spi_data, e.data);
      check("event_latency", 32'(cyc - e.cyc), 32'(SS + 2));
    end
  endtask

  // Monitor: one pop per latch strobe start or error pulse.
  initial begin
    logic prev;
    int   low;
    prev = 1'b1; low = 0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        prev = 1'b1; low = 0;
      end else begin
        if (!bus.latch_data_sn) begin
          low++;
          if (prev) pop_cmp(1'b0);
        end else if (!prev) begin
          check("latch_low_cycles", 32'(low), 32'(LC));
          low = 0;
        end
        if (bus.frame_error) pop_cmp(1'b1);
        prev = bus.latch_data_sn;
      end
    end
  end

  // act: 0 none, 1 enable_sn pulse, 2 async reset, applied before bit act_at.
  task automatic send_frame(input logic [63:0] data, input int nbits, input bit chk_miso,
                            input logic [31:0] miso_exp, input int act_at, input int act,
                            input bit expect_ev, input bit exp_err, input logic [31:0] exp_data,
                            input int post);
    bit chk;
    chk = chk_miso;
    bus.cs_n = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == act_at && act == 1) begin
        bus.enable_sn = 1'b1; tick(3); bus.enable_sn = 1'b0;
        chk = 1'b0;
      end
      if (i == act_at && act == 2) begin
        #3 reset = 1'b1;
        #1;
        check("rst_spi_data", bus.spi_data, 32'h0);
        check("rst_latch", 32'(bus.latch_data_sn), 32'h1);
        check("rst_error", 32'(bus.frame_error), 32'h0);
        check("rst_miso", 32'(bus.miso), 32'h0);
        tick(2);
        reset = 1'b0;
        chk = 1'b0;
      end
      bus.mosi = data[nbits-1-i];
      tick(5);
      if (chk && i < 32)
        check($sformatf("miso_bit%0d", i), 32'(bus.miso), 32'(miso_exp[31-i]));
      bus.sclk = 1'b1;
      tick(5);
      bus.sclk = 1'b0;
    end
    tick(6);
    if (expect_ev) exp_q.push_back('{exp_err, exp_data, cyc});
    bus.cs_n = 1'b1;
    tick(post);
  endtask

  initial begin
    reset = 1'b1;
    bus.enable_sn = 1'b0; bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.readback_data = 16'h0; bus.readback_valid_n = 1'b1;
    #12;
    check("reset_spi_data", bus.spi_data, 32'h0);
    check("reset_latch", 32'(bus.latch_data_sn), 32'h1);
    check("reset_error", 32'(bus.frame_error), 32'h0);
    check("reset_miso", 32'(bus.miso), 32'h0);
    @(posedge clock); #2;
    reset = 1'b0;
    tick(6);

    send_frame(64'hA53C1234, 32, 1'b1, 32'h0, -1, 0, 1'b1, 1'b0, 32'hA53C1234, 10);
    check("miso_idle", 32'(bus.miso), 32'h0);

    // short then long frame: errors, spi_data untouched
    send_frame(64'h12345678, 31, 1'b0, 32'h0, -1, 0, 1'b1, 1'b1, 32'hA53C1234, 10);
    send_frame(64'h123456789, 33, 1'b0, 32'h0, -1, 0, 1'b1, 1'b1, 32'hA53C1234, 10);

    bus.readback_data = 16'hBEEF; bus.readback_valid_n = 1'b0;
    tick(1);
    bus.readback_valid_n = 1'b1; bus.readback_data = 16'h0;
    tick(4);
    send_frame(64'h0F0FF0F0, 32, 1'b1, 32'hBEEF0000, -1, 0, 1'b1, 1'b0, 32'h0F0FF0F0, 10);
    check("miso_after_cs", 32'(bus.miso), 32'h0);

    // second cs fall lands inside LATCH and must be ignored
    send_frame(64'h11223344, 32, 1'b0, 32'h0, -1, 0, 1'b1, 1'b0, 32'h11223344, 2);
    send_frame(64'h55667788, 32, 1'b0, 32'h0, -1, 0, 1'b0, 1'b0, 32'h0, 10);
    check("b2b_spi_data", bus.spi_data, 32'h11223344);

    send_frame(64'hDEADBEEF, 32, 1'b0, 32'h0, 20, 1, 1'b0, 1'b0, 32'h0, 10);
    check("enable_spi_data", bus.spi_data, 32'h11223344);
    send_frame(64'h00000001, 32, 1'b1, 32'hBEEF0000, -1, 0, 1'b1, 1'b0, 32'h00000001, 10);

    send_frame(64'hCAFEF00D, 32, 1'b1, 32'hBEEF0000, 12, 2, 1'b0, 1'b0, 32'h0, 10);
    check("post_rst_spi_data", bus.spi_data, 32'h0);
    send_frame(64'h89ABCDEF, 32, 1'b1, 32'h0, -1, 0, 1'b1, 1'b0, 32'h89ABCDEF, 10);

    tick(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
